jump_ctrl: RTL

Vertical-motion controller for the player sprite. Consumes the one-cycle jump pulse and 5-bit height code produced by the audio pitch-threshold stage and turns them into a per-frame vertical position under constant gravity. Runs a rise/fall state machine stepped by an internal physics tick, and drives the sprite renderer's Y coordinate and status pulses.

---
 rtl/jump_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jump_ctrl.sv
// jump_ctrl: vertical-motion controller for the player sprite.
// A free-running divider produces the physics tick; a rise/fall state machine
// turns an accepted jump (launch velocity = i_height) into per-tick Y updates
// under constant gravity. Screen Y grows downward, so rising subtracts.
// Optional feature: define JUMP_DOUBLE_EN to enable a single air-jump credit
// that lets one extra jump be taken while in RISE or FALL.
module jump_ctrl #(
    parameter int TICK_DIV = 833333,
    parameter int GROUND_Y = 400,
    parameter int Y_W      = 10,
    parameter int GRAVITY  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_jump,
    input  logic [4:0]     i_height,
    output logic [Y_W-1:0] o_y,
    output logic           o_airborne,
    output logic           o_apex,
    output logic           o_landed,
    output logic           o_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int YX_W  = Y_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    // Gravity above the velocity range behaves like 31: apex on the first
    // rise tick and full-speed fall.
    localparam logic [4:0]       GRAV_V   = (GRAVITY > 31) ? 5'd31 : 5'(GRAVITY);
    localparam logic [Y_W-1:0]   GROUND   = Y_W'(GROUND_Y);
    localparam logic [YX_W-1:0]  GROUND_X = YX_W'(GROUND_Y);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RISE = 2'd1;
    localparam logic [1:0] ST_FALL = 2'd2;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    logic [1:0]       state, state_n;
    logic [Y_W-1:0]   y, y_n;
    logic [4:0]       v, v_n;
    logic             apex_q, apex_n;
    logic             landed_q, landed_n;

    logic             jump_ok;
    logic             mid_jump;
    logic [Y_W-1:0]   v_ext;
    logic [Y_W-1:0]   y_rise;
    logic [5:0]       v_sum;
    logic [4:0]       v_fall;
    logic [YX_W-1:0]  y_fall;

    assign tick = (tick_cnt == CNT_LAST);

    // Physics-step divider: counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state is always assigned non-blocking so every
        // flop samples the pre-edge values of its neighbours.
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    assign jump_ok = i_jump & (i_height != 5'd0);

    // Rise step: move up by V, clamped at the top of the screen.
    assign v_ext  = Y_W'(v);
    assign y_rise = (y >= v_ext) ? (y - v_ext) : '0;

    // Fall step: speed up by gravity (capped at 31), then move down; the
    // extra sum bit keeps a near-bottom Y from wrapping before the compare.
    assign v_sum  = {1'b0, v} + {1'b0, GRAV_V};
    assign v_fall = v_sum[5] ? 5'd31 : v_sum[4:0];
    assign y_fall = {1'b0, y} + YX_W'(v_fall);

`ifdef JUMP_DOUBLE_EN
    logic air_credit;

    assign mid_jump = air_credit & jump_ok & (state != ST_IDLE);

    // Air-jump credit: granted on launch, spent on the air jump, dropped on landing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            air_credit <= 1'b0;
        end else if ((state == ST_IDLE) && jump_ok) begin
            air_credit <= 1'b1;
        end else if (mid_jump || landed_n) begin
            air_credit <= 1'b0;
        end
    end
`else
    assign mid_jump = 1'b0;
`endif

    // Next-state logic for the rise/fall machine and its status pulses.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case leaves a value unassigned and no latch is inferred.
        state_n  = state;
        y_n      = y;
        v_n      = v;
        apex_n   = 1'b0;
        landed_n = 1'b0;

        case (state)
            ST_IDLE: begin
                // Launch consumes the cycle; Y first moves on the next tick.
                if (jump_ok) begin
                    v_n     = i_height;
                    state_n = ST_RISE;
                end
            end
            ST_RISE, ST_FALL: begin
                if (mid_jump) begin
                    // Air jump beats a coincident tick: that step is skipped.
                    v_n     = i_height;
                    state_n = ST_RISE;
                end else if (tick && (state == ST_RISE)) begin
                    y_n = y_rise;
                    if (v <= GRAV_V) begin
                        v_n     = 5'd0;
                        state_n = ST_FALL;
                        apex_n  = 1'b1;
                    end else begin
                        v_n = v - GRAV_V;
                    end
                end else if (tick) begin
                    v_n = v_fall;
                    if (y_fall >= GROUND_X) begin
                        y_n      = GROUND;
                        v_n      = 5'd0;
                        state_n  = ST_IDLE;
                        landed_n = 1'b1;
                    end else begin
                        y_n = y_fall[Y_W-1:0];
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                y_n     = GROUND;
                v_n     = 5'd0;
            end
        endcase
    end

    // Motion registers; reset puts the sprite straight back on the ground.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            y        <= GROUND;
            v        <= 5'd0;
            apex_q   <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state    <= state_n;
            y        <= y_n;
            v        <= v_n;
            apex_q   <= apex_n;
            landed_q <= landed_n;
        end
    end

    assign o_y        = y;
    assign o_airborne = (state != ST_IDLE);
    assign o_apex     = apex_q;
    assign o_landed   = landed_q;
    assign o_tick     = tick;

endmodule
